// File: rtl/player_motion_box.sv
// Player sprite box: holds the on-screen position, runs the walk/jump/fall motion once per frame,
// and registers the draw request and colour for the objects mux.
module player_motion_box #(
    parameter int          OBJECT_WIDTH  = 32,
    parameter int          OBJECT_HEIGHT = 32,
    parameter int          INIT_X        = 64,
    parameter int          INIT_Y        = 416,
    parameter int          FLOOR_Y       = 416,
    parameter int          SCREEN_W      = 640,
    parameter int          WALK_SPEED    = 2,
    parameter int          JUMP_VELOCITY = 12,
    parameter int          GRAVITY       = 1,
    parameter int          MAX_FALL      = 8,
    parameter logic [7:0]  OBJECT_COLOR  = 8'hE4
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        leftKey,
    input  logic        rightKey,
    input  logic        jumpKey,
    output logic        drawingRequest,
    output logic [7:0]  RGBout,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        airborne
);

    typedef enum logic [1:0] {ST_GROUND, ST_JUMP, ST_FALL} state_t;

    localparam logic [10:0]        X_INIT  = 11'(INIT_X);
    localparam logic [10:0]        Y_INIT  = 11'(INIT_Y);
    localparam logic [10:0]        X_MAX   = 11'(SCREEN_W - OBJECT_WIDTH);
    localparam logic [10:0]        WALK    = 11'(WALK_SPEED);
    localparam logic [10:0]        FLOOR11 = 11'(FLOOR_Y);
    localparam logic signed [11:0] FLOOR12 = 12'(FLOOR_Y);
    localparam logic [11:0]        OW12    = 12'(OBJECT_WIDTH);
    localparam logic [11:0]        OH12    = 12'(OBJECT_HEIGHT);
    localparam logic signed [5:0]  VY_JUMP = 6'(-JUMP_VELOCITY);
    localparam logic signed [5:0]  VY_GRAV = 6'(GRAVITY);
    localparam logic signed [5:0]  VY_MAX  = 6'(MAX_FALL);

    state_t             r_state;
    logic [10:0]        r_x;
    logic [10:0]        r_y;
    logic signed [5:0]  r_vy;
    logic               r_draw;
    logic [7:0]         r_rgb;
    logic               r_airborne;

    logic [10:0]        w_x_next;
    logic signed [11:0] w_vy_ext;
    logic signed [11:0] w_y_sum;
    logic signed [5:0]  w_vy_inc;
    logic [11:0]        w_px;
    logic [11:0]        w_py;
    logic [11:0]        w_x_lo;
    logic [11:0]        w_y_lo;
    logic               w_inside;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_x_next = r_x;
        if (leftKey && !rightKey)
            w_x_next = (r_x < WALK) ? '0 : r_x - WALK;
        else if (rightKey && !leftKey)
            w_x_next = (r_x > X_MAX - WALK) ? X_MAX : r_x + WALK;
    end

    // Y is widened to signed 12 bits so a jump through the ceiling shows up as a negative sum.
    assign w_vy_ext = {{6{r_vy[5]}}, r_vy};
    assign w_y_sum  = $signed({1'b0, r_y}) + w_vy_ext;
    assign w_vy_inc = r_vy + VY_GRAV;

    assign w_px     = {1'b0, pixelX};
    assign w_py     = {1'b0, pixelY};
    assign w_x_lo   = {1'b0, r_x};
    assign w_y_lo   = {1'b0, r_y};
    assign w_inside = (w_px >= w_x_lo) && (w_px < w_x_lo + OW12) &&
                      (w_py >= w_y_lo) && (w_py < w_y_lo + OH12);

    // NOTE: reset is synchronous and checked first, so it beats a coincident startOfFrame.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state    <= ST_GROUND;
            r_x        <= X_INIT;
            r_y        <= Y_INIT;
            r_vy       <= '0;
            r_draw     <= 1'b0;
            r_rgb      <= 8'h00;
            r_airborne <= 1'b0;
        end else begin
            r_draw <= w_inside;
            r_rgb  <= OBJECT_COLOR;
            if (startOfFrame) begin
                r_x <= w_x_next;
                case (r_state)
                    ST_GROUND: begin
                        if (jumpKey) begin
                            r_vy       <= VY_JUMP;
                            r_state    <= ST_JUMP;
                            r_airborne <= 1'b1;
                        end else begin
                            r_vy <= '0;
                        end
                    end
                    ST_JUMP: begin
                        if (w_y_sum[11]) begin
                            r_y     <= '0;
                            r_vy    <= '0;
                            r_state <= ST_FALL;
                        end else begin
                            r_y  <= w_y_sum[10:0];
                            r_vy <= w_vy_inc;
                            if (!w_vy_inc[5])
                                r_state <= ST_FALL;
                        end
                    end
                    ST_FALL: begin
                        if (w_y_sum >= FLOOR12) begin
                            r_y        <= FLOOR11;
                            r_vy       <= '0;
                            r_state    <= ST_GROUND;
                            r_airborne <= 1'b0;
                        end else begin
                            r_y  <= w_y_sum[10:0];
                            r_vy <= (w_vy_inc > VY_MAX) ? VY_MAX : w_vy_inc;
                        end
                    end
                    default: begin
                        r_state    <= ST_GROUND;
                        r_airborne <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign drawingRequest = r_draw;
    assign RGBout         = r_rgb;
    assign topLeftX       = r_x;
    assign topLeftY       = r_y;
    assign airborne       = r_airborne;

endmodule

// File: tb/tb_player_motion_box.sv
// Bench for player_motion_box: two instances (floor start and near-ceiling start) share stimulus
// and are compared every cycle against a physics-level model, plus hand-computed literal checks.
module tb_player_motion_box;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic [10:0] pixelX = '0;
    logic [10:0] pixelY = '0;
    logic        leftKey = 1'b0;
    logic        rightKey = 1'b0;
    logic        jumpKey = 1'b0;

    logic        draw0, draw1, air0, air1;
    logic [7:0]  rgb0, rgb1;
    logic [10:0] x0, y0, x1, y1;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    player_motion_box dut0 (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .pixelX(pixelX), .pixelY(pixelY),
        .leftKey(leftKey), .rightKey(rightKey), .jumpKey(jumpKey),
        .drawingRequest(draw0), .RGBout(rgb0),
        .topLeftX(x0), .topLeftY(y0), .airborne(air0)
    );

    player_motion_box #(.INIT_Y(5), .FLOOR_Y(416)) dut1 (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .pixelX(pixelX), .pixelY(pixelY),
        .leftKey(leftKey), .rightKey(rightKey), .jumpKey(jumpKey),
        .drawingRequest(draw1), .RGBout(rgb1),
        .topLeftX(x1), .topLeftY(y1), .airborne(air1)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Physics-level model: position, velocity and an airborne flag. Rising is simply vy < 0.
    int mx[2], my[2], mvy[2], mrgb[2];
    bit mair[2], mdraw[2];

    function automatic int init_y(input int k);
        return (k == 0) ? 416 : 5;
    endfunction

    task automatic model_step();
        int px, py, ny;
        px = int'(pixelX);
        py = int'(pixelY);
        for (int k = 0; k < 2; k++) begin
            if (!resetN) begin
                mx[k] = 64; my[k] = init_y(k); mvy[k] = 0; mair[k] = 0;
                mdraw[k] = 0; mrgb[k] = 0;
            end else begin
                mdraw[k] = (px >= mx[k]) && (px < mx[k] + 32) && (py >= my[k]) && (py < my[k] + 32);
                mrgb[k]  = 'hE4;
                if (startOfFrame) begin
                    if (leftKey && !rightKey)  mx[k] = (mx[k] - 2 < 0) ? 0 : mx[k] - 2;
                    if (rightKey && !leftKey)  mx[k] = (mx[k] + 2 > 608) ? 608 : mx[k] + 2;
                    if (!mair[k]) begin
                        if (jumpKey) begin mvy[k] = -12; mair[k] = 1; end
                    end else if (mvy[k] < 0) begin
                        ny = my[k] + mvy[k];
                        if (ny < 0) begin my[k] = 0; mvy[k] = 0; end
                        else begin my[k] = ny; mvy[k] = mvy[k] + 1; end
                    end else begin
                        ny = my[k] + mvy[k];
                        if (ny >= 416) begin my[k] = 416; mvy[k] = 0; mair[k] = 0; end
                        else begin my[k] = ny; mvy[k] = (mvy[k] + 1 > 8) ? 8 : mvy[k] + 1; end
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        #1;
        if (check_en) begin
            check("x0", int'(x0), mx[0]);        check("y0", int'(y0), my[0]);
            check("air0", int'(air0), int'(mair[0]));
            check("draw0", int'(draw0), int'(mdraw[0]));
            check("rgb0", int'(rgb0), mrgb[0]);
            check("x1", int'(x1), mx[1]);        check("y1", int'(y1), my[1]);
            check("air1", int'(air1), int'(mair[1]));
            check("draw1", int'(draw1), int'(mdraw[1]));
            check("rgb1", int'(rgb1), mrgb[1]);
        end
    end

    task automatic rand_pixel();
        int k, px, py;
        k = int'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) begin
            px = int'($urandom_range(0, 2047));
            py = int'($urandom_range(0, 2047));
        end else begin
            px = mx[k] + int'($urandom_range(0, 40)) - 4;
            py = my[k] + int'($urandom_range(0, 40)) - 4;
        end
        pixelX = 11'((px < 0) ? 0 : px);
        pixelY = 11'((py < 0) ? 0 : py);
    endtask

    task automatic cycle(input bit rst, input bit sof, input bit l, input bit r, input bit j);
        @(negedge clk);
        resetN = rst; startOfFrame = sof;
        leftKey = l; rightKey = r; jumpKey = j;
        rand_pixel();
    endtask

    task automatic noise_cycle();
        cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic pix(input int px, input int py);
        noise_cycle();
        pixelX = 11'(px);
        pixelY = 11'(py);
    endtask

    task automatic frame(input bit l, input bit r, input bit j);
        cycle(1'b1, 1'b1, l, r, j);
        repeat (3) noise_cycle();
    endtask

    int jump_y[12] = '{404, 393, 383, 374, 366, 359, 353, 348, 344, 341, 339, 338};
    int fall_y[15] = '{338, 339, 341, 344, 348, 353, 359, 366, 374, 382, 390, 398, 406, 414, 416};

    initial begin
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        check_en = 1'b1;
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("rst_x", int'(x0), 64);    check("rst_y", int'(y0), 416);
        check("rst_air", int'(air0), 0); check("rst_draw", int'(draw0), 0);
        check("rst_rgb", int'(rgb0), 0); check("rst_y1", int'(y1), 5);

        frame(1'b0, 1'b0, 1'b0);
        check("idle_x", int'(x0), 64); check("idle_y", int'(y0), 416);
        check("idle_air", int'(air0), 0);

        pix(0, 0);
        pix(64, 416);
        check("draw_lag", int'(draw0), 0);
        pix(96, 416);
        check("draw_in", int'(draw0), 1);
        pix(95, 447);
        check("draw_right_edge", int'(draw0), 0);
        pix(0, 0);
        check("draw_corner", int'(draw0), 1);
        check("draw_rgb", int'(rgb0), 'hE4);

        repeat (10) frame(1'b0, 1'b1, 1'b0);
        check("right10_x", int'(x0), 84);
        repeat (280) frame(1'b0, 1'b1, 1'b0);
        check("right_sat_x", int'(x0), 608);
        repeat (3) frame(1'b1, 1'b1, 1'b0);
        check("both_keys_x", int'(x0), 608);
        repeat (5) frame(1'b1, 1'b0, 1'b0);
        check("left5_x", int'(x0), 598);
        repeat (310) frame(1'b1, 1'b0, 1'b0);
        check("left_sat_x", int'(x0), 0);
        repeat (32) frame(1'b0, 1'b1, 1'b0);
        check("back_x", int'(x0), 64);

        frame(1'b0, 1'b0, 1'b1);
        check("jump0_y", int'(y0), 416); check("jump0_air", int'(air0), 1);
        check("jump0_y1", int'(y1), 5);
        for (int i = 0; i < 12; i++) begin
            frame(1'b0, 1'b0, 1'b1);
            check($sformatf("jump_y[%0d]", i), int'(y0), jump_y[i]);
            if (i == 0) check("ceil_y1", int'(y1), 0);
            if (i == 1) check("ceil_hold_y1", int'(y1), 0);
            if (i == 2) check("ceil_fall_y1", int'(y1), 1);
        end
        for (int i = 0; i < 15; i++) begin
            frame(1'b0, 1'b0, 1'b0);
            check($sformatf("fall_y[%0d]", i), int'(y0), fall_y[i]);
            check($sformatf("fall_air[%0d]", i), int'(air0), (i == 14) ? 0 : 1);
        end
        frame(1'b0, 1'b0, 1'b0);
        check("landed_y", int'(y0), 416); check("landed_air", int'(air0), 0);

        frame(1'b0, 1'b1, 1'b1);
        repeat (3) frame(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("midjump_rst_x", int'(x0), 64);   check("midjump_rst_y", int'(y0), 416);
        check("midjump_rst_air", int'(air0), 0); check("midjump_rst_draw", int'(draw0), 0);

        repeat (300) begin
            if ($urandom_range(0, 49) == 0)
                cycle(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1);
            cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 4)) noise_cycle();
        end

        @(negedge clk);
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
